// File: rtl/fsm_iter_ctrl_pkg.sv
// Shared definitions for the iterative-operation controller.
// State codes are fixed so debug probes and waveforms stay stable.
package fsm_iter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_INIT = 3'b001,
        ST_ITER = 3'b010,
        ST_DONE = 3'b011,
        ST_TOUT = 3'b100
    } state_e;

endpackage

// File: rtl/fsm_iter_ctrl_iter_counter.sv
// Iteration counter with sync clear, enable and terminal-count flag.
// tc_o flags the last permitted iteration (count == MAX_ITER-1).
module fsm_iter_ctrl_iter_counter #(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_ITER - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/fsm_iter_ctrl.sv
// Iterative-operation controller: start/zero handshake with
// iteration limit, abort and optional ready-hold until ack.
module fsm_iter_ctrl
    import fsm_iter_ctrl_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MAX_ITER   = 200,
    parameter int READY_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             zero,
    input  logic             ack,
    output logic             do_iter,
    output logic             busy,
    output logic             ready,
    output logic             timeout,
    output logic [CNT_W-1:0] iter_cnt
);

    state_e state_q;
    state_e state_d;

    logic dbg_idle;
    logic dbg_init;
    logic dbg_iter;
    logic dbg_done;
    logic dbg_tout;
    logic cnt_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (abort)     state_d = ST_IDLE;
                else if (zero) state_d = ST_DONE;
                else           state_d = ST_ITER;
            end
            ST_ITER: begin
                if (abort)       state_d = ST_IDLE;
                else if (zero)   state_d = ST_DONE;
                else if (cnt_tc) state_d = ST_TOUT;
            end
            ST_DONE, ST_TOUT: begin
                // Without hold the result is a single-cycle pulse
                if (READY_HOLD == 0 || ack || abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dbg_idle = (state_q == ST_IDLE);
        dbg_init = (state_q == ST_INIT);
        dbg_iter = (state_q == ST_ITER);
        dbg_done = (state_q == ST_DONE);
        dbg_tout = (state_q == ST_TOUT);
        do_iter  = dbg_iter;
        busy     = dbg_init | dbg_iter;
        ready    = dbg_done | dbg_tout;
        timeout  = dbg_tout;
    end

    fsm_iter_ctrl_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (dbg_idle & start),
        .en_i  (dbg_iter),
        .cnt_o (iter_cnt),
        .tc_o  (cnt_tc)
    );

endmodule

// File: tb/tb_fsm_iter_ctrl.sv
// Directed bench: pulse-mode instance driven from a vector table,
// hold-mode instance driven by hand-written multi-cycle sequences.
module tb_fsm_iter_ctrl;

    typedef struct {
        logic        start;
        logic        abort;
        logic        zero;
        logic        ack;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic       a_start, a_abort, a_zero, a_ack;
    logic       a_do, a_busy, a_ready, a_tout;
    logic [7:0] a_cnt;

    logic       b_start, b_abort, b_zero, b_ack;
    logic       b_do, b_busy, b_ready, b_tout;
    logic [7:0] b_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tbl [36];

    wire [11:0] a_out = {a_do, a_busy, a_ready, a_tout, a_cnt};
    wire [11:0] b_out = {b_do, b_busy, b_ready, b_tout, b_cnt};

    always #5 clk = ~clk;

    fsm_iter_ctrl #(
        .CNT_W      (8),
        .MAX_ITER   (4),
        .READY_HOLD (0)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (a_start),
        .abort    (a_abort),
        .zero     (a_zero),
        .ack      (a_ack),
        .do_iter  (a_do),
        .busy     (a_busy),
        .ready    (a_ready),
        .timeout  (a_tout),
        .iter_cnt (a_cnt)
    );

    fsm_iter_ctrl #(
        .CNT_W      (8),
        .MAX_ITER   (6),
        .READY_HOLD (1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .abort    (b_abort),
        .zero     (b_zero),
        .ack      (b_ack),
        .do_iter  (b_do),
        .busy     (b_busy),
        .ready    (b_ready),
        .timeout  (b_tout),
        .iter_cnt (b_cnt)
    );

    function automatic vec_t v(
        input logic s, input logic a, input logic z, input logic k,
        input logic d, input logic b, input logic r, input logic t,
        input logic [7:0] c
    );
        vec_t x;
        x.start = s;
        x.abort = a;
        x.zero  = z;
        x.ack   = k;
        x.exp   = {d, b, r, t, c};
        return x;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got do/busy/rdy/tout=%b cnt=%0d, want %b cnt=%0d",
                     nm, act[11:8], act[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic chk_b(input string nm, input logic d, input logic b,
                         input logic r, input logic t, input logic [7:0] c);
        chk(nm, b_out, {d, b, r, t, c});
    endtask

    initial begin
        // T2 normal: zero on 3rd ITER cycle
        tbl[0]  = v(1,0,0,0, 0,0,0,0, 0);
        tbl[1]  = v(0,0,0,0, 0,1,0,0, 0);
        tbl[2]  = v(0,0,0,0, 1,1,0,0, 0);
        tbl[3]  = v(0,0,0,0, 1,1,0,0, 1);
        tbl[4]  = v(0,0,1,0, 1,1,0,0, 2);
        tbl[5]  = v(0,0,0,0, 0,0,1,0, 3);
        tbl[6]  = v(0,0,0,0, 0,0,0,0, 3);
        // T3 zero in INIT; start during DONE ignored
        tbl[7]  = v(1,0,0,0, 0,0,0,0, 3);
        tbl[8]  = v(0,0,1,0, 0,1,0,0, 0);
        tbl[9]  = v(1,0,0,1, 0,0,1,0, 0);
        tbl[10] = v(0,0,0,0, 0,0,0,0, 0);
        // T4 timeout at MAX_ITER=4
        tbl[11] = v(1,0,0,0, 0,0,0,0, 0);
        tbl[12] = v(0,0,0,0, 0,1,0,0, 0);
        tbl[13] = v(0,0,0,0, 1,1,0,0, 0);
        tbl[14] = v(0,0,0,0, 1,1,0,0, 1);
        tbl[15] = v(0,0,0,0, 1,1,0,0, 2);
        tbl[16] = v(0,0,0,0, 1,1,0,0, 3);
        tbl[17] = v(0,0,0,0, 0,0,1,1, 4);
        tbl[18] = v(0,0,0,0, 0,0,0,0, 4);
        // zero on the limit cycle wins -> DONE
        tbl[19] = v(1,0,0,0, 0,0,0,0, 4);
        tbl[20] = v(0,0,0,0, 0,1,0,0, 0);
        tbl[21] = v(0,0,0,0, 1,1,0,0, 0);
        tbl[22] = v(0,0,0,0, 1,1,0,0, 1);
        tbl[23] = v(0,0,0,0, 1,1,0,0, 2);
        tbl[24] = v(0,0,1,0, 1,1,0,0, 3);
        tbl[25] = v(0,0,0,0, 0,0,1,0, 4);
        tbl[26] = v(0,0,0,0, 0,0,0,0, 4);
        // T5 abort on 2nd ITER, start while busy ignored
        tbl[27] = v(1,0,0,0, 0,0,0,0, 4);
        tbl[28] = v(1,0,0,0, 0,1,0,0, 0);
        tbl[29] = v(1,0,0,0, 1,1,0,0, 0);
        tbl[30] = v(0,1,0,0, 1,1,0,0, 1);
        tbl[31] = v(0,0,0,0, 0,0,0,0, 2);
        // abort ignored in IDLE, abort honoured in INIT
        tbl[32] = v(0,1,0,0, 0,0,0,0, 2);
        tbl[33] = v(1,1,0,0, 0,0,0,0, 2);
        tbl[34] = v(0,1,0,0, 0,1,0,0, 0);
        tbl[35] = v(0,0,0,0, 0,0,0,0, 0);

        rst = 1'b1;
        {a_start, a_abort, a_zero, a_ack} = '0;
        {b_start, b_abort, b_zero, b_ack} = '0;
        repeat (2) @(negedge clk);
        chk("reset_a", a_out, 12'h000);
        chk("reset_b", b_out, 12'h000);
        rst = 1'b0;

        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            a_start = tbl[i].start;
            a_abort = tbl[i].abort;
            a_zero  = tbl[i].zero;
            a_ack   = tbl[i].ack;
            chk($sformatf("vec%0d", i), a_out, tbl[i].exp);
        end
        @(negedge clk);
        {a_start, a_abort, a_zero, a_ack} = '0;

        // T6 hold mode: DONE held until ack
        @(negedge clk); b_start = 1'b1;
        chk_b("h_idle", 0,0,0,0, 0);
        @(negedge clk); b_start = 1'b0; b_zero = 1'b1;
        chk_b("h_init", 0,1,0,0, 0);
        @(negedge clk); b_zero = 1'b0;
        chk_b("h_done", 0,0,1,0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_start = (i == 5);
            chk_b($sformatf("h_done_hold%0d", i), 0,0,1,0, 0);
        end
        @(negedge clk); b_start = 1'b0; b_ack = 1'b1;
        chk_b("h_done_ack", 0,0,1,0, 0);
        @(negedge clk); b_ack = 1'b0; b_start = 1'b1;
        chk_b("h_idle_after_ack", 0,0,0,0, 0);
        @(negedge clk); b_start = 1'b0;
        chk_b("h_restart", 0,1,0,0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_b($sformatf("h_iter%0d", k), 1,1,0,0, 8'(k));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_b($sformatf("h_tout_hold%0d", i), 0,0,1,1, 6);
        end
        @(negedge clk); b_abort = 1'b1;
        chk_b("h_tout_abort", 0,0,1,1, 6);
        @(negedge clk); b_abort = 1'b0;
        chk_b("h_idle_after_abort", 0,0,0,0, 6);

        // T1 async reset in the middle of ITER with iter_cnt=5
        @(negedge clk); b_start = 1'b1;
        chk_b("r_idle", 0,0,0,0, 6);
        @(negedge clk); b_start = 1'b0;
        chk_b("r_init", 0,1,0,0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_b($sformatf("r_iter%0d", k), 1,1,0,0, 8'(k));
        end
        rst = 1'b1;
        #1;
        chk_b("r_async", 0,0,0,0, 0);
        chk("r_async_a", a_out, 12'h000);
        @(negedge clk); rst = 1'b0;
        chk_b("r_held", 0,0,0,0, 0);
        @(negedge clk);
        chk_b("r_after", 0,0,0,0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
